hold_sequencer: RTL and testbench

- Registered, stateful replacement for the combinational jump/hold control path in the tinyriscv core.
- Accepts jump requests from ex and hold requests from ex, clint, rib and jtag, and arbitrates them by fixed priority.
- After a jump, sequences a multi-cycle pipeline flush; runs a jtag halt/drain handshake; watches the rib bus for stalls that last too long.
- Drives pc_reg, if_id and id_ex hold/jump inputs.

---
 rtl/hold_sequencer_if.sv | 25 ++
 rtl/hold_sequencer.sv | 131 +++++++++++++
 tb/tb_hold_sequencer.sv | 177 +++++++++++++++++
 3 files changed

// File: rtl/hold_sequencer_if.sv
// Request/response bundle between the ex/clint/rib/jtag hold sources and the hold sequencer.
// The master side raises requests; the slave side (the sequencer) returns registered controls.
interface hold_sequencer_if;
    logic        jump_req_i;
    logic [31:0] jump_addr_i;
    logic        hold_ex_i;
    logic        hold_clint_i;
    logic        hold_rib_i;
    logic        jtag_halt_req_i;
    logic        jump_flag_o;
    logic [31:0] jump_addr_o;
    logic [2:0]  hold_flag_o;
    logic        jtag_halted_o;
    logic        bus_timeout_o;

    modport master (
        output jump_req_i, jump_addr_i, hold_ex_i, hold_clint_i, hold_rib_i, jtag_halt_req_i,
        input  jump_flag_o, jump_addr_o, hold_flag_o, jtag_halted_o, bus_timeout_o
    );

    modport slave (
        input  jump_req_i, jump_addr_i, hold_ex_i, hold_clint_i, hold_rib_i, jtag_halt_req_i,
        output jump_flag_o, jump_addr_o, hold_flag_o, jtag_halted_o, bus_timeout_o
    );
endinterface

// File: rtl/hold_sequencer.sv
// Registered jump/hold arbiter: fixed-priority jump > ex/clint > rib > jtag, multi-cycle flush,
// jtag halt/drain handshake and rib stall watchdog. All outputs registered, 1-cycle latency.
module hold_sequencer #(
    parameter int FLUSH_CYCLES = 2,
    parameter int BUS_TIMEOUT  = 255
) (
    input  logic             clk,
    input  logic             rst,
    hold_sequencer_if.slave  bus
);
    localparam logic [2:0]  HOLD_NONE   = 3'd0;
    localparam logic [2:0]  HOLD_PC     = 3'd1;
    localparam logic [2:0]  HOLD_ID     = 3'd3;
    localparam logic [3:0]  FLUSH_LOAD  = 4'(FLUSH_CYCLES - 1);
    localparam logic [15:0] TIMEOUT_VAL = 16'(BUS_TIMEOUT);
    localparam logic [15:0] CNT_MAX     = 16'hFFFF;

    typedef enum logic [2:0] {
        S_IDLE,
        S_FLUSH,
        S_BUS_WAIT,
        S_HALTING,
        S_HALTED
    } state_t;

    state_t      state;
    logic [3:0]  flush_cnt;
    logic [15:0] bus_cnt;
    logic        jump_flag;
    logic [31:0] jump_addr;
    logic [2:0]  hold_flag;
    logic        halted;
    logic        timeout;
    logic        hold_core;

    assign hold_core = bus.hold_ex_i | bus.hold_clint_i;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state     <= S_IDLE;
            flush_cnt <= 4'd0;
            bus_cnt   <= 16'd0;
            jump_flag <= 1'b0;
            jump_addr <= 32'd0;
            hold_flag <= HOLD_NONE;
            halted    <= 1'b0;
            timeout   <= 1'b0;
        end else begin
            jump_flag <= 1'b0;
            timeout   <= 1'b0;
            // A jump pre-empts everything except a fully halted core; in HALTING it is forwarded
            if (bus.jump_req_i && state != S_HALTED) begin
                jump_flag <= 1'b1;
                jump_addr <= bus.jump_addr_i;
                flush_cnt <= FLUSH_LOAD;
                bus_cnt   <= 16'd0;
                hold_flag <= HOLD_ID;
                state     <= (state == S_HALTING) ? S_HALTING : S_FLUSH;
            end else begin
                case (state)
                    S_IDLE, S_FLUSH: begin
                        if (state == S_FLUSH && flush_cnt != 4'd0) begin
                            flush_cnt <= flush_cnt - 4'd1;
                            hold_flag <= HOLD_ID;
                        end else if (hold_core) begin
                            state     <= S_IDLE;
                            hold_flag <= HOLD_ID;
                        end else if (bus.hold_rib_i) begin
                            state     <= S_BUS_WAIT;
                            bus_cnt   <= 16'd1;
                            timeout   <= (TIMEOUT_VAL == 16'd1);
                            hold_flag <= HOLD_PC;
                        end else if (bus.jtag_halt_req_i) begin
                            state     <= S_HALTING;
                            flush_cnt <= FLUSH_LOAD;
                            hold_flag <= HOLD_ID;
                        end else begin
                            state     <= S_IDLE;
                            hold_flag <= HOLD_NONE;
                        end
                    end
                    S_BUS_WAIT: begin
                        if (!bus.hold_rib_i) begin
                            state     <= S_IDLE;
                            bus_cnt   <= 16'd0;
                            hold_flag <= hold_core ? HOLD_ID : HOLD_NONE;
                        end else begin
                            // Saturated counter must not re-fire the timeout pulse
                            if (bus_cnt != CNT_MAX) begin
                                bus_cnt <= bus_cnt + 16'd1;
                            end
                            timeout   <= (bus_cnt != CNT_MAX) && (bus_cnt + 16'd1 == TIMEOUT_VAL);
                            hold_flag <= hold_core ? HOLD_ID : HOLD_PC;
                        end
                    end
                    S_HALTING: begin
                        hold_flag <= HOLD_ID;
                        if (!bus.jtag_halt_req_i) begin
                            state     <= S_IDLE;
                            hold_flag <= HOLD_NONE;
                        end else if (flush_cnt == 4'd0) begin
                            state  <= S_HALTED;
                            halted <= 1'b1;
                        end else begin
                            flush_cnt <= flush_cnt - 4'd1;
                        end
                    end
                    S_HALTED: begin
                        if (!bus.jtag_halt_req_i) begin
                            state     <= S_IDLE;
                            halted    <= 1'b0;
                            hold_flag <= HOLD_NONE;
                        end else begin
                            hold_flag <= HOLD_ID;
                        end
                    end
                    default: begin
                        state     <= S_IDLE;
                        hold_flag <= HOLD_NONE;
                    end
                endcase
            end
        end
    end

    assign bus.jump_flag_o   = jump_flag;
    assign bus.jump_addr_o   = jump_addr;
    assign bus.hold_flag_o   = hold_flag;
    assign bus.jtag_halted_o = halted;
    assign bus.bus_timeout_o = timeout;
endmodule

// File: tb/tb_hold_sequencer.sv
// Directed bench for hold_sequencer with default FLUSH_CYCLES=2, BUS_TIMEOUT=255.
module tb_hold_sequencer;
    logic clk = 1'b0;
    logic rst = 1'b1;
    int   checks = 0;
    int   errors = 0;

    hold_sequencer_if bus();

    hold_sequencer #(.FLUSH_CYCLES(2), .BUS_TIMEOUT(255)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic chk_out(input string tag, input logic [31:0] flag, input logic [31:0] addr,
                           input logic [31:0] hold, input logic [31:0] halted, input logic [31:0] to);
        chk({tag, "_flag"},   32'(bus.jump_flag_o),   flag);
        chk({tag, "_addr"},   bus.jump_addr_o,        addr);
        chk({tag, "_hold"},   32'(bus.hold_flag_o),   hold);
        chk({tag, "_halted"}, 32'(bus.jtag_halted_o), halted);
        chk({tag, "_to"},     32'(bus.bus_timeout_o), to);
    endtask

    // Cycle i=1 is the edge that enters (or stays in) BUS_WAIT; timeout expected only at pulse_at
    task automatic run_bus(input string tag, input int n, input int pulse_at);
        for (int i = 1; i <= n; i++) begin
            step();
            chk({tag, "_hold"}, 32'(bus.hold_flag_o), 32'd1);
            chk({tag, "_to"}, 32'(bus.bus_timeout_o), 32'(i == pulse_at));
        end
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: simulation did not complete within time limit");
        $fatal(1);
    end

    initial begin
        bus.jump_req_i      = 1'b0;
        bus.jump_addr_i     = 32'd0;
        bus.hold_ex_i       = 1'b0;
        bus.hold_clint_i    = 1'b0;
        bus.hold_rib_i      = 1'b0;
        bus.jtag_halt_req_i = 1'b0;

        #12;
        chk_out("reset", 0, 0, 0, 0, 0);
        rst = 1'b0;
        step();
        chk_out("idle", 0, 0, 0, 0, 0);

        // Single jump: one-cycle pulse, two cycles of Hold_Id
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h100;
        step();
        bus.jump_req_i = 1'b0; bus.jump_addr_i = 32'hDEAD;
        chk_out("j1_e0", 1, 32'h100, 3, 0, 0);
        step();
        chk_out("j1_e1", 0, 32'h100, 3, 0, 0);
        step();
        chk_out("j1_e2", 0, 32'h100, 0, 0, 0);

        // Second jump on the 2nd flush cycle restarts the flush
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h100;
        step();
        bus.jump_req_i = 1'b0;
        chk_out("j2_a0", 1, 32'h100, 3, 0, 0);
        step();
        chk_out("j2_a1", 0, 32'h100, 3, 0, 0);
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h200;
        step();
        bus.jump_req_i = 1'b0;
        chk_out("j2_b0", 1, 32'h200, 3, 0, 0);
        step();
        chk_out("j2_b1", 0, 32'h200, 3, 0, 0);
        step();
        chk_out("j2_b2", 0, 32'h200, 0, 0, 0);

        // Long rib stall: Hold_Pc throughout, single timeout pulse on the 255th stall cycle
        bus.hold_rib_i = 1'b1;
        run_bus("rib300", 300, 255);
        bus.hold_rib_i = 1'b0;
        step();
        chk_out("rib_rel", 0, 32'h200, 0, 0, 0);

        // Jump beats rib in the same cycle; counter cleared by every jump
        bus.hold_rib_i = 1'b1; bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h80;
        step();
        bus.jump_req_i = 1'b0;
        chk_out("jr_e0", 1, 32'h80, 3, 0, 0);
        step();
        chk_out("jr_e1", 0, 32'h80, 3, 0, 0);
        run_bus("jr_segA", 200, 0);
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h84;
        step();
        bus.jump_req_i = 1'b0;
        chk_out("jr_f0", 1, 32'h84, 3, 0, 0);
        step();
        chk_out("jr_f1", 0, 32'h84, 3, 0, 0);
        run_bus("jr_segB", 260, 255);
        bus.hold_rib_i = 1'b0;
        step();
        chk_out("jr_rel", 0, 32'h84, 0, 0, 0);

        // JTAG halt: drain for FLUSH_CYCLES, then halted; jumps ignored while halted
        bus.jtag_halt_req_i = 1'b1;
        step();
        chk_out("jt_h0", 0, 32'h84, 3, 0, 0);
        step();
        chk_out("jt_h1", 0, 32'h84, 3, 0, 0);
        step();
        chk_out("jt_h2", 0, 32'h84, 3, 1, 0);
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h300;
        step();
        bus.jump_req_i = 1'b0;
        chk_out("jt_ign", 0, 32'h84, 3, 1, 0);
        bus.jtag_halt_req_i = 1'b0;
        step();
        chk_out("jt_rel", 0, 32'h84, 0, 0, 0);

        // Jump during HALTING is forwarded and reloads the drain count
        bus.jtag_halt_req_i = 1'b1;
        step();
        chk_out("jh_h0", 0, 32'h84, 3, 0, 0);
        bus.jump_req_i = 1'b1; bus.jump_addr_i = 32'h400;
        step();
        bus.jump_req_i = 1'b0;
        chk_out("jh_j0", 1, 32'h400, 3, 0, 0);
        step();
        chk_out("jh_j1", 0, 32'h400, 3, 0, 0);
        step();
        chk_out("jh_j2", 0, 32'h400, 3, 1, 0);
        bus.jtag_halt_req_i = 1'b0;
        step();
        chk_out("jh_rel", 0, 32'h400, 0, 0, 0);

        // ex hold has priority over rib while idle
        bus.hold_ex_i = 1'b1; bus.hold_rib_i = 1'b1;
        step();
        chk_out("ex_pri", 0, 32'h400, 3, 0, 0);
        bus.hold_ex_i = 1'b0; bus.hold_rib_i = 1'b0;
        step();
        chk_out("ex_rel", 0, 32'h400, 0, 0, 0);

        // Asynchronous reset in the middle of a stall count
        bus.hold_rib_i = 1'b1;
        run_bus("rst_pre", 100, 0);
        rst = 1'b1;
        #2;
        chk_out("rst_async", 0, 0, 0, 0, 0);
        @(negedge clk);
        rst = 1'b0;
        run_bus("rst_post", 260, 255);
        bus.hold_rib_i = 1'b0;
        step();
        chk_out("rst_rel", 0, 0, 0, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
